// File: rtl/sram_access_seq.sv
// Serial-address SRAM access sequencer.
// Shifts in an address MSB first and loads it into an address counter. Single-byte
// reads and writes then run with fixed SETUP / STROBE / HOLD phases on ce_n/oe_n/we_n.
// All SRAM-facing strobes come straight from flops, so they cannot glitch.
module sram_access_seq #(
    parameter int unsigned ADDR_W     = 21,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              si,
    input  logic              shift_en,
    input  logic [2:0]        cmd,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              cmd_drop,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_doe,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic              inc_q, inc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              doe_q, doe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              accept;

    // A command is taken only when no access is running; done cycle counts as idle.
    assign accept = cmd_valid && !busy_q;

    // Next-state and next registered outputs for the access FSM.
    always_comb begin
        state_d = state_q;
        sr_d    = shift_en ? {sr_q[ADDR_W-2:0], si} : sr_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        inc_d   = inc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        drop_d  = drop_q | (cmd_valid & busy_q);
        doe_d   = doe_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (cmd)
                        3'd1: begin
                            // Uses the pre-shift register value.
                            addr_d = sr_q;
                            done_d = 1'b1;
                        end
                        3'd2, 3'd3, 3'd4, 3'd5: begin
                            state_d = StSetup;
                            is_wr_d = (cmd == 3'd3) || (cmd == 3'd5);
                            inc_d   = (cmd == 3'd4) || (cmd == 3'd5);
                            busy_d  = 1'b1;
                            ce_n_d  = 1'b0;
                            if ((cmd == 3'd3) || (cmd == 3'd5)) begin
                                doe_d  = 1'b1;
                                dout_d = wdata;
                            end
                        end
                        3'd6: begin
                            addr_d = addr_q + ADDR_W'(1);
                            done_d = 1'b1;
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = CntW'(STROBE_CYC - 1);
                oe_n_d  = is_wr_q;
                we_n_d  = !is_wr_q;
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        rdata_d = sram_din;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                state_d = StIdle;
                ce_n_d  = 1'b1;
                doe_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (inc_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset forces the SRAM bus inactive immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            doe_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            doe_q   <= doe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_drop  = drop_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_access_seq.sv
// Scoreboard bench for sram_access_seq: stimulus pushes expected completions, a monitor
// pops and checks them on every done pulse, and per-cycle counters check strobe timing.
module tb_sram_access_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        si;
    logic        shift_en;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        cmd_drop;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dout;
    logic        sram_doe;
    logic [7:0]  sram_din;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    sram_access_seq #(.ADDR_W(21), .DATA_W(8), .STROBE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .shift_en(shift_en), .cmd(cmd),
        .cmd_valid(cmd_valid), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .cmd_drop(cmd_drop), .sram_addr(sram_addr), .sram_dout(sram_dout),
        .sram_doe(sram_doe), .sram_din(sram_din), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Small SRAM model indexed by the low address byte.
    logic [7:0] mem [256];
    assign sram_din = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_doe) mem[sram_addr[7:0]] <= sram_dout;
    end

    typedef struct {
        bit          chk_rdata;
        logic [7:0]  rdata;
        logic [20:0] addr;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    int busy_cnt, we_cnt, we_good, oe_cnt, doe_cnt, viol;
    logic [7:0] exp_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_addr", {11'd0, sram_addr}, {11'd0, e.addr});
                if (e.chk_rdata) check("done_rdata", {24'd0, rdata}, {24'd0, e.rdata});
            end
        end
    end

    // Per-cycle strobe observation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (!sram_we_n) we_cnt++;
            if (!sram_we_n && sram_doe && sram_dout == exp_wd) we_good++;
            if (!sram_oe_n) oe_cnt++;
            if (sram_doe) doe_cnt++;
            if ((!sram_oe_n && !sram_we_n) || (!sram_we_n && !sram_doe)) viol++;
        end
    end

    task automatic clr_cnt();
        busy_cnt = 0; we_cnt = 0; we_good = 0; oe_cnt = 0; doe_cnt = 0;
    endtask

    // Caller positions at a negedge; command is presented for exactly one rising edge.
    task automatic drive_cmd(input logic [2:0] c, input logic [7:0] w);
        cmd = c; wdata = w; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push(input bit chk, input logic [7:0] rd, input logic [20:0] a);
        exp_t e;
        e.chk_rdata = chk; e.rdata = rd; e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic shift_addr(input logic [20:0] v);
        for (int i = 20; i >= 0; i--) begin
            @(negedge clk);
            shift_en = 1'b1; si = v[i];
            @(posedge clk); #1;
        end
        shift_en = 1'b0;
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (lat >= max) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic load_addr(input logic [20:0] a);
        int lat;
        shift_addr(a);
        @(negedge clk);
        push(1'b0, 8'h00, a);
        drive_cmd(3'd1, 8'h00);
        wait_done(10, lat);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h11] = 8'h3C;
        mem[8'hFF] = 8'h77;
        viol = 0; exp_wd = 8'h00; clr_cnt();
        rst_n = 1'b0; si = 1'b0; shift_en = 1'b0; cmd = 3'd0; cmd_valid = 1'b0;
        wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_doe}, 32'hE);
        check("rst_flags", {29'd0, busy, done, cmd_drop}, 32'd0);
        check("rst_addr", {11'd0, sram_addr}, 32'd0);
        check("rst_data", {16'd0, rdata, sram_dout}, 32'd0);
        rst_n = 1'b1;

        // Shift 0x012345 then LOAD: done one cycle after accept, never busy.
        shift_addr(21'h012345);
        @(negedge clk);
        clr_cnt();
        push(1'b0, 8'h00, 21'h012345);
        drive_cmd(3'd1, 8'h00);
        wait_done(10, lat);
        check("load_latency", lat, 1);
        check("load_busy", busy_cnt, 0);

        // WRITE_INC 0xA5 at 0x10.
        load_addr(21'h000010);
        @(negedge clk);
        clr_cnt(); exp_wd = 8'hA5;
        push(1'b0, 8'h00, 21'h000011);
        drive_cmd(3'd5, 8'hA5);
        wait_done(20, lat);
        check("wr_latency", lat, 5);
        check("wr_busy_cycles", busy_cnt, 4);
        check("wr_we_cycles", we_cnt, 2);
        check("wr_we_data_ok", we_good, 2);
        check("wr_mem", {24'd0, mem[8'h10]}, 32'hA5);

        // READ at 0x11 returns 0x3C, address unchanged.
        @(negedge clk);
        clr_cnt();
        push(1'b1, 8'h3C, 21'h000011);
        drive_cmd(3'd2, 8'h00);
        wait_done(20, lat);
        check("rd_oe_cycles", oe_cnt, 2);
        check("rd_doe_cycles", doe_cnt, 0);
        check("rd_busy_cycles", busy_cnt, 4);

        // LOAD 0x1FFFFF then READ_INC wraps to zero.
        load_addr(21'h1FFFFF);
        @(negedge clk);
        push(1'b1, 8'h77, 21'h000000);
        drive_cmd(3'd4, 8'h00);
        wait_done(20, lat);

        // WRITE, dropped READ mid-access, second WRITE on the done cycle.
        load_addr(21'h000020);
        @(negedge clk);
        check("drop_before", {31'd0, cmd_drop}, 32'd0);
        exp_wd = 8'h11;
        push(1'b0, 8'h00, 21'h000020);
        drive_cmd(3'd3, 8'h11);
        @(negedge clk);
        drive_cmd(3'd2, 8'h00);
        wait_done(20, lat);
        check("drop_flag", {31'd0, cmd_drop}, 32'd1);
        check("drop_rdata_kept", {24'd0, rdata}, 32'h77);
        exp_wd = 8'h22;
        push(1'b0, 8'h00, 21'h000020);
        drive_cmd(3'd3, 8'h22);
        @(negedge clk);
        check("b2b_busy_no_gap", {31'd0, busy}, 32'd1);
        wait_done(20, lat);
        check("b2b_mem", {24'd0, mem[8'h20]}, 32'h22);

        // Reset during STROBE of a WRITE.
        load_addr(21'h000030);
        @(negedge clk);
        exp_wd = 8'h5A;
        drive_cmd(3'd3, 8'h5A);
        repeat (2) @(negedge clk);
        check("strobe_we_low", {31'd0, sram_we_n}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_doe}, 32'hE);
        check("async_rst_addr", {11'd0, sram_addr}, 32'd0);
        check("async_rst_flags", {29'd0, busy, done, cmd_drop}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_no_resume", {31'd0, busy}, 32'd0);

        check("pending_expected", exp_q.size(), 0);
        check("strobe_violations", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
